// File: rtl/crc_pkg.sv
// Shared definitions for the CRC-32 FCS appender: FSM states, CRC constants,
// and the reflected-polynomial table entry function.
package crc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_FCS0 = 3'd2,
        ST_FCS1 = 3'd3,
        ST_FCS2 = 3'd4,
        ST_FCS3 = 3'd5
    } crc_state_t;

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

    // One entry of the byte-wise lookup table: eight LSB-first shift/XOR steps.
    function automatic logic [31:0] crc_table_entry(input logic [7:0] idx);
        logic [31:0] c;
        c = {24'h00_0000, idx};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational single-byte CRC-32 update using a constant 256-entry table.
module crc32_byte_step
    import crc_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_out
);

    logic [31:0] table_rom [256];
    logic [7:0]  table_idx;

    // Table contents are elaborated constants; synthesis folds them into a ROM.
    generate
        for (genvar gi = 0; gi < 256; gi++) begin : g_table
            assign table_rom[gi] = crc_table_entry(8'(gi));
        end
    endgenerate

    assign table_idx = crc_in[7:0] ^ byte_in;
    assign crc_out   = {8'h00, crc_in[31:8]} ^ table_rom[table_idx];

endmodule

// File: rtl/crc32_fcs_appender.sv
// Byte-stream pass-through that appends a little-endian CRC-32 FCS after the
// last payload byte of each frame, with a single registered output stage.
module crc32_fcs_appender
    import crc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [31:0]      fcs_out,
    output logic             fcs_done,
    output logic [CNT_W-1:0] frame_cnt
);

    crc_state_t       state_reg;
    logic [31:0]      crc_reg;
    logic [31:0]      crc_next;
    logic [31:0]      fcs_reg;
    logic [7:0]       m_data_reg;
    logic             m_valid_reg;
    logic             m_last_reg;
    logic [31:0]      fcs_out_reg;
    logic             fcs_done_reg;
    logic [CNT_W-1:0] frame_cnt_reg;
    logic [7:0]       fcs_byte [4];
    logic             accept;
    logic             out_take;
    logic             in_payload;

    crc32_byte_step u_step (
        .crc_in  (crc_reg),
        .byte_in (s_data),
        .crc_out (crc_next)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fcs_lane
            assign fcs_byte[gi] = fcs_reg[8*gi +: 8];
        end
    endgenerate

    assign in_payload = (state_reg == ST_IDLE) || (state_reg == ST_DATA);
    assign s_ready    = in_payload && (!m_valid_reg || m_ready);
    assign accept     = s_valid && s_ready;
    assign out_take   = m_valid_reg && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            crc_reg       <= CRC_INIT;
            fcs_reg       <= 32'h0000_0000;
            m_data_reg    <= 8'h00;
            m_valid_reg   <= 1'b0;
            m_last_reg    <= 1'b0;
            fcs_out_reg   <= 32'h0000_0000;
            fcs_done_reg  <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            fcs_done_reg <= 1'b0;
            // The final FCS byte leaving the output stage completes the frame.
            if (out_take && m_last_reg) begin
                fcs_done_reg  <= 1'b1;
                fcs_out_reg   <= fcs_reg;
                frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
            end

            case (state_reg)
                ST_IDLE, ST_DATA: begin
                    if (accept) begin
                        m_data_reg  <= s_data;
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= 1'b0;
                        if (s_last) begin
                            // FCS is frozen here, so the accumulator can restart
                            // immediately for the next frame.
                            fcs_reg   <= ~crc_next;
                            crc_reg   <= CRC_INIT;
                            state_reg <= ST_FCS0;
                        end else begin
                            crc_reg   <= crc_next;
                            state_reg <= ST_DATA;
                        end
                    end else if (out_take) begin
                        m_valid_reg <= 1'b0;
                        m_last_reg  <= 1'b0;
                    end
                end
                ST_FCS0: begin
                    if (out_take) begin
                        m_data_reg  <= fcs_byte[0];
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= 1'b0;
                        state_reg   <= ST_FCS1;
                    end
                end
                ST_FCS1: begin
                    if (out_take) begin
                        m_data_reg  <= fcs_byte[1];
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= 1'b0;
                        state_reg   <= ST_FCS2;
                    end
                end
                ST_FCS2: begin
                    if (out_take) begin
                        m_data_reg  <= fcs_byte[2];
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= 1'b0;
                        state_reg   <= ST_FCS3;
                    end
                end
                ST_FCS3: begin
                    // Returning to IDLE here lets the next frame's first byte
                    // enter during the m_last handshake.
                    if (out_take) begin
                        m_data_reg  <= fcs_byte[3];
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    crc_reg     <= CRC_INIT;
                    m_valid_reg <= 1'b0;
                    m_last_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign m_data    = m_data_reg;
    assign m_valid   = m_valid_reg;
    assign m_last    = m_last_reg;
    assign fcs_out   = fcs_out_reg;
    assign fcs_done  = fcs_done_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_crc32_fcs_appender.sv
// Self-checking bench: directed and randomized frames compared against a
// bit-serial CRC-32 model and an expected byte-stream queue.
module tb_crc32_fcs_appender;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    logic [31:0]      fcs_out;
    logic             fcs_done;
    logic [CNT_W-1:0] frame_cnt;

    crc32_fcs_appender #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .fcs_out   (fcs_out),
        .fcs_done  (fcs_done),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  stim_q[$];
    logic [8:0]  exp_q[$];
    logic [31:0] exp_fcs_q[$];
    int          exp_cnt_q[$];
    logic [8:0]  obs_q[$];
    int          obs_cyc[$];
    logic [31:0] done_fcs_q[$];
    int          done_cnt_q[$];
    logic [7:0]  pl_q[$];
    int          exp_cnt;
    int          cyc = 0;
    logic        rnd_ready = 1'b0;
    logic        gaps = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Output monitor, sampling mid-cycle when all DUT outputs are settled.
    initial begin : monitor
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(m_valid), 32'(1));
                    chk("stall_data", 32'(m_data), 32'(prev_data));
                    chk("stall_last", 32'(m_last), 32'(prev_last));
                end
                if (m_valid && m_ready) begin
                    obs_q.push_back({m_last, m_data});
                    obs_cyc.push_back(cyc);
                end
                if (fcs_done) begin
                    done_fcs_q.push_back(fcs_out);
                    done_cnt_q.push_back(int'(frame_cnt));
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    initial begin : ready_driver
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            m_ready = rnd_ready ? ($urandom_range(1) == 1) : 1'b1;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: payload, then ~CRC-32 (bit-serial, reflected) LSB byte first.
    task automatic add_frame();
        logic [31:0] crc;
        logic [31:0] fcs;
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < pl_q.size(); i++) begin
            stim_q.push_back({(i == pl_q.size() - 1), pl_q[i]});
            exp_q.push_back({1'b0, pl_q[i]});
            crc = crc ^ {24'h0, pl_q[i]};
            for (int b = 0; b < 8; b++) begin
                crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
            end
        end
        fcs = ~crc;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({(k == 3), fcs[8*k +: 8]});
        end
        exp_fcs_q.push_back(fcs);
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        exp_cnt_q.push_back(exp_cnt);
    endtask

    task automatic clear_queues();
        stim_q.delete();
        exp_q.delete();
        exp_fcs_q.delete();
        exp_cnt_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        done_fcs_q.delete();
        done_cnt_q.delete();
    endtask

    task automatic drive_stream();
        int budget;
        for (int i = 0; i < stim_q.size(); i++) begin
            @(negedge clk);
            if (gaps) begin
                while ($urandom_range(2) == 0) begin
                    s_valid = 1'b0;
                    s_data  = 8'($urandom);
                    s_last  = 1'($urandom);
                    @(negedge clk);
                end
            end
            s_valid = 1'b1;
            {s_last, s_data} = stim_q[i];
            budget = 0;
            #1;
            while (!s_ready && budget < 1000) begin
                @(negedge clk);
                #1;
                budget++;
            end
            chk("s_ready_wait", 32'(s_ready), 32'(1));
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_check(input string tag);
        int budget;
        int n;
        budget = 0;
        while ((obs_q.size() < exp_q.size() || done_fcs_q.size() < exp_fcs_q.size())
               && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_nbytes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        end
        chk({tag, "_ndone"}, 32'(done_fcs_q.size()), 32'(exp_fcs_q.size()));
        n = (done_fcs_q.size() < exp_fcs_q.size()) ? done_fcs_q.size() : exp_fcs_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_fcs%0d", tag, i), done_fcs_q[i], exp_fcs_q[i]);
            chk($sformatf("%s_cnt%0d", tag, i), 32'(done_cnt_q[i]), 32'(exp_cnt_q[i]));
        end
        $display("frame group %s: bytes=%0d frames=%0d fcs_out=%h frame_cnt=%0d",
                 tag, obs_q.size(), done_fcs_q.size(), fcs_out, frame_cnt);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        #3;
        chk({tag, "_m_valid"}, 32'(m_valid), 32'(0));
        chk({tag, "_m_last"}, 32'(m_last), 32'(0));
        chk({tag, "_m_data"}, 32'(m_data), 32'(0));
        chk({tag, "_fcs_out"}, fcs_out, 32'(0));
        chk({tag, "_fcs_done"}, 32'(fcs_done), 32'(0));
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(0));
        chk({tag, "_s_ready"}, 32'(s_ready), 32'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_queues();
        exp_cnt = 0;
    endtask

    task automatic load_check_seq();
        pl_q.delete();
        for (int i = 0; i < 9; i++) pl_q.push_back(8'h31 + 8'(i));
    endtask

    initial begin : stimulus
        int len;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        exp_cnt = 0;

        do_reset("reset");

        // "123456789" with m_ready held high
        load_check_seq();
        add_frame();
        drive_stream();
        wait_check("check_seq");
        chk("check_seq_fcs_const", fcs_out, 32'hCBF4_3926);
        chk("check_seq_cnt", 32'(frame_cnt), 32'(1));

        // Single zero byte
        do_reset("rst1");
        pl_q.delete();
        pl_q.push_back(8'h00);
        add_frame();
        drive_stream();
        wait_check("single");
        chk("single_fcs_const", fcs_out, 32'hD202_EF8D);
        chk("single_cnt", 32'(frame_cnt), 32'(1));

        // Two back-to-back frames, no idle output cycle
        do_reset("rst2");
        load_check_seq();
        add_frame();
        add_frame();
        drive_stream();
        wait_check("b2b");
        if (obs_cyc.size() == 26) begin
            chk("b2b_span", 32'(obs_cyc[25] - obs_cyc[0]), 32'(25));
        end else begin
            chk("b2b_span_count", 32'(obs_cyc.size()), 32'(26));
        end

        // Random backpressure and input gaps
        do_reset("rst3");
        rnd_ready = 1'b1;
        gaps      = 1'b1;
        load_check_seq();
        add_frame();
        drive_stream();
        wait_check("stall");
        rnd_ready = 1'b0;
        gaps      = 1'b0;

        // Reset after four bytes, then a clean frame
        do_reset("rst4");
        load_check_seq();
        pl_q = pl_q[0:3];
        for (int i = 0; i < 4; i++) stim_q.push_back({1'b0, pl_q[i]});
        drive_stream();
        repeat (3) @(negedge clk);
        do_reset("midrst");
        load_check_seq();
        add_frame();
        drive_stream();
        wait_check("after_rst");
        chk("after_rst_fcs_const", fcs_out, 32'hCBF4_3926);
        chk("after_rst_cnt", 32'(frame_cnt), 32'(1));

        // Five random frames; 2-bit counter runs 1,2,3,0,1
        do_reset("rst5");
        rnd_ready = 1'b1;
        gaps      = 1'b1;
        for (int f = 0; f < 5; f++) begin
            pl_q.delete();
            len = $urandom_range(12, 1);
            for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom));
            add_frame();
        end
        drive_stream();
        wait_check("wrap");
        rnd_ready = 1'b0;
        gaps      = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
